// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared types for the inter-stage registers: occupancy states,
//            per-stage payload layouts and control-bit kill masks.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [31:0] pc_plus4;
  } mem_wb_t;

  localparam int IF_ID_WIDTH  = $bits(if_id_t);
  localparam int ID_EX_WIDTH  = $bits(id_ex_t);
  localparam int EX_MEM_WIDTH = $bits(ex_mem_t);
  localparam int MEM_WB_WIDTH = $bits(mem_wb_t);

  // Kill masks cover the leading control bits that would write state.
  localparam logic [IF_ID_WIDTH-1:0]  IF_ID_KILL  = '0;
  localparam logic [ID_EX_WIDTH-1:0]  ID_EX_KILL  = {3'b111, {(ID_EX_WIDTH-3){1'b0}}};
  localparam logic [EX_MEM_WIDTH-1:0] EX_MEM_KILL = {3'b111, {(EX_MEM_WIDTH-3){1'b0}}};
  localparam logic [MEM_WB_WIDTH-1:0] MEM_WB_KILL = {1'b1, {(MEM_WB_WIDTH-1){1'b0}}};

  function automatic logic [1:0] occ_of(stage_state_t s);
    case (s)
      EMPTY:   return 2'd0;
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_if
// Brief    : Valid/ready stage bus with flush and occupancy observation.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_stage_if #(
  parameter int PAYLOAD_WIDTH = 104
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [PAYLOAD_WIDTH-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [PAYLOAD_WIDTH-1:0] out_data;
  logic [1:0]               occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module   : pipe_slot
// Brief    : One valid bit plus payload register; load wins over clear.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_slot #(
  parameter int WIDTH = 104
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_load,
  input  wire logic             i_clear,
  input  wire logic [WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // Data only moves on load, so bubbles leave the register untouched.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end else if (i_clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage
// Brief    : Payload-agnostic pipeline register with valid/ready, flush,
//            control-bit kill mask and optional two-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int                     PAYLOAD_WIDTH = 104,
  parameter logic [PAYLOAD_WIDTH-1:0] KILL_MASK   = '0,
  parameter bit                     SKID          = 1'b1
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  pipe_stage_if.slave bus
);

  logic                     w_accept;
  logic                     w_consume;
  logic                     w_in_ready;
  logic [1:0]               w_occupancy;
  logic                     w_main_load;
  logic                     w_main_clear;
  logic [PAYLOAD_WIDTH-1:0] w_main_din;
  logic                     w_main_valid;
  logic [PAYLOAD_WIDTH-1:0] w_main_data;

  assign w_accept  = bus.in_valid & w_in_ready & ~bus.flush;
  assign w_consume = w_main_valid & bus.out_ready;

  pipe_slot #(.WIDTH(PAYLOAD_WIDTH)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_din),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  generate
    if (SKID) begin : g_skid
      stage_state_t             state_q, state_d;
      logic [1:0]               occ_q, occ_d;
      logic                     in_ready_q, in_ready_d;
      logic                     main_load, main_clear;
      logic                     skid_load, skid_clear;
      logic                     skid_valid;
      logic [PAYLOAD_WIDTH-1:0] skid_data;

      pipe_slot #(.WIDTH(PAYLOAD_WIDTH)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (skid_load),
        .i_clear (skid_clear),
        .i_data  (bus.in_data),
        .o_valid (skid_valid),
        .o_data  (skid_data)
      );

      always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        case (state_q)
          EMPTY: begin
            if (w_accept) begin
              state_d   = ONE;
              main_load = 1'b1;
            end
          end
          ONE: begin
            if (w_accept && w_consume) begin
              main_load = 1'b1;
            end else if (w_accept) begin
              state_d   = TWO;
              skid_load = 1'b1;
            end else if (w_consume) begin
              state_d    = EMPTY;
              main_clear = 1'b1;
            end
          end
          TWO: begin
            if (w_consume) begin
              state_d    = ONE;
              main_load  = 1'b1;
              skid_clear = 1'b1;
            end
          end
          default: state_d = EMPTY;
        endcase
        // Flush overrides every transfer, including a pending skid->main move.
        if (bus.flush) begin
          state_d    = EMPTY;
          main_load  = 1'b0;
          skid_load  = 1'b0;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
        in_ready_d = (state_d != TWO);
        occ_d      = occ_of(state_d);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q    <= EMPTY;
          occ_q      <= 2'd0;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          occ_q      <= occ_d;
          in_ready_q <= in_ready_d;
        end
      end

      assign w_in_ready   = in_ready_q;
      assign w_occupancy  = occ_q;
      assign w_main_load  = main_load;
      assign w_main_clear = main_clear;
      // A live skid entry is by construction the next one main must take.
      assign w_main_din   = skid_valid ? skid_data : bus.in_data;
    end else begin : g_single
      assign w_in_ready   = ~w_main_valid | bus.out_ready;
      assign w_occupancy  = {1'b0, w_main_valid};
      assign w_main_load  = w_accept;
      assign w_main_clear = bus.flush | (w_consume & ~w_accept);
      assign w_main_din   = bus.in_data;
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_main_valid;
  assign bus.out_data  = w_main_data & ~(KILL_MASK & {PAYLOAD_WIDTH{~w_main_valid}});
  assign bus.occupancy = w_occupancy;

endmodule
`default_nettype wire
